// File: rtl/reg_window_ctrl.sv
// Window-pointer controller for a 4-window register file: tracks call depth and
// spills/fills the oldest window to a memory save area when the windows run out.
module reg_window_ctrl #(
    parameter int NUM_WND   = 4,
    parameter int XFER_REGS = 2,
    parameter int ADDR_W    = 8,
    parameter int DEPTH_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              call,
    input  logic              ret,
    output logic [1:0]        wnd_sel,
    output logic              stall,
    output logic [1:0]        xfer_wnd,
    output logic [1:0]        xfer_idx,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              fill_reg_write,
    output logic              wnd_err
);

    localparam int RES_W = $clog2(NUM_WND + 1);
    localparam logic [RES_W-1:0]   RES_FULL  = RES_W'(NUM_WND);
    localparam logic [RES_W-1:0]   RES_ONE   = RES_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [1:0]         IDX_LAST  = 2'(XFER_REGS - 1);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t             state_reg;
    logic [1:0]         cwp_reg;
    logic [RES_W-1:0]   resident_reg;
    logic [DEPTH_W-1:0] depth_reg;
    logic [ADDR_W-1:0]  save_ptr_reg;
    logic [1:0]         idx_reg;
    logic               err_reg;

    logic call_only, ret_only, idle, full, single;
    logic start_spill, start_fill;
    logic [1:0] cwp_inc, cwp_dec;

    assign call_only = call & ~ret;
    assign ret_only  = ret & ~call;
    assign idle      = (state_reg == IDLE);
    assign full      = (resident_reg == RES_FULL);
    assign single    = (resident_reg == RES_ONE);
    assign cwp_inc   = cwp_reg + 2'd1;
    assign cwp_dec   = cwp_reg - 2'd1;

    // Stall must rise in the very cycle the call/return is decoded.
    assign start_spill = idle & call_only & full & (depth_reg != DEPTH_MAX);
    assign start_fill  = idle & ret_only & single & (depth_reg != '0);

    always_comb begin
        wnd_sel        = cwp_reg;
        wnd_err        = err_reg;
        stall          = ~idle | start_spill | start_fill;
        mem_req        = ~idle;
        mem_wr         = (state_reg == SPILL);
        fill_reg_write = (state_reg == FILL) & mem_ack;
        xfer_wnd       = 2'd0;
        xfer_idx       = 2'd0;
        mem_addr       = '0;
        if ((state_reg == SPILL) || start_spill) begin
            xfer_wnd = cwp_inc;
        end else if ((state_reg == FILL) || start_fill) begin
            xfer_wnd = cwp_dec;
        end
        if (!idle) begin
            xfer_idx = idx_reg;
        end else if (start_fill) begin
            xfer_idx = IDX_LAST;
        end
        if (state_reg == SPILL) begin
            mem_addr = save_ptr_reg;
        end else if (state_reg == FILL) begin
            mem_addr = save_ptr_reg - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cwp_reg      <= 2'd0;
            resident_reg <= RES_ONE;
            depth_reg    <= '0;
            save_ptr_reg <= '0;
            idx_reg      <= 2'd0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (call_only) begin
                        if (!full) begin
                            cwp_reg      <= cwp_inc;
                            resident_reg <= resident_reg + RES_ONE;
                        end else if (depth_reg != DEPTH_MAX) begin
                            state_reg <= SPILL;
                            idx_reg   <= 2'd0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else if (ret_only) begin
                        if (!single) begin
                            cwp_reg      <= cwp_dec;
                            resident_reg <= resident_reg - RES_ONE;
                        end else if (depth_reg != '0) begin
                            state_reg <= FILL;
                            idx_reg   <= IDX_LAST;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                SPILL: begin
                    if (mem_ack) begin
                        save_ptr_reg <= save_ptr_reg + ADDR_W'(1);
                        idx_reg      <= idx_reg + 2'd1;
                        // The spilled window becomes the new current one; resident count is unchanged.
                        if (idx_reg == IDX_LAST) begin
                            cwp_reg   <= cwp_inc;
                            depth_reg <= depth_reg + DEPTH_W'(1);
                            state_reg <= IDLE;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        save_ptr_reg <= save_ptr_reg - ADDR_W'(1);
                        idx_reg      <= idx_reg - 2'd1;
                        if (idx_reg == 2'd0) begin
                            cwp_reg   <= cwp_dec;
                            depth_reg <= depth_reg - DEPTH_W'(1);
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Scoreboard bench for reg_window_ctrl: memory transactions are queued as expected
// and checked by a monitor on each acknowledged request; status is checked inline.
module tb_reg_window_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       ack_direct = 1'b0;
    logic       ack_delayed = 1'b0;
    logic       ack_mode = 1'b0;
    logic       mem_ack;
    logic [1:0] wnd_sel, xfer_wnd, xfer_idx;
    logic       stall, mem_req, mem_wr, fill_reg_write, wnd_err;
    logic [7:0] mem_addr;

    int tests_run = 0;
    int tests_failed = 0;
    int wait_cnt = 0;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [1:0] wnd;
        logic [1:0] idx;
    } txn_t;

    txn_t exp_q[$];

    assign mem_ack = ack_mode ? ack_delayed : ack_direct;

    always #5 clk = ~clk;

    reg_window_ctrl #(
        .NUM_WND(4), .XFER_REGS(2), .ADDR_W(8), .DEPTH_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .call(call), .ret(ret),
        .wnd_sel(wnd_sel), .stall(stall), .xfer_wnd(xfer_wnd), .xfer_idx(xfer_idx),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .fill_reg_write(fill_reg_write), .wnd_err(wnd_err)
    );

    // Memory responder: acknowledges each request after two idle cycles.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            ack_delayed = 1'b0;
            wait_cnt = 0;
        end else if (ack_delayed) begin
            ack_delayed = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt == 2) begin
                ack_delayed = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic txn_t mk(input logic wr, input logic [7:0] addr,
                                input logic [1:0] wnd, input logic [1:0] idx);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wnd = wnd; t.idx = idx;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end else begin
            $display("[TB] check %s = 0x%0h", name, got);
        end
    endtask

    task automatic monitor_loop();
        txn_t got, req;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && mem_req && mem_ack) begin
                got = {mem_wr, mem_addr, xfer_wnd, xfer_idx};
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL txn_unexpected: got wr=%0d addr=%0d wnd=%0d idx=%0d, required none",
                             got.wr, got.addr, got.wnd, got.idx);
                end else begin
                    req = exp_q.pop_front();
                    if (got !== req || fill_reg_write !== ~req.wr) begin
                        tests_failed++;
                        $display("FAIL txn: got wr=%0d addr=%0d wnd=%0d idx=%0d frw=%0d, required wr=%0d addr=%0d wnd=%0d idx=%0d frw=%0d",
                                 got.wr, got.addr, got.wnd, got.idx, fill_reg_write,
                                 req.wr, req.addr, req.wnd, req.idx, ~req.wr);
                    end else begin
                        $display("[TB] txn wr=%0d addr=%0d wnd=%0d idx=%0d frw=%0d",
                                 got.wr, got.addr, got.wnd, got.idx, fill_reg_write);
                    end
                end
            end
            if (fill_reg_write && !(mem_req && !mem_wr && mem_ack)) begin
                tests_run++;
                tests_failed++;
                $display("FAIL fill_reg_write_stray: got 1, required 0");
            end
        end
    endtask

    task automatic wait_cyc();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    // Issues a call that must spill; counts cycles with stall high.
    task automatic run_spill(output int cnt);
        cnt = 0;
        call = 1'b1;
        ack_direct = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (!stall) break;
            cnt++;
            wait_cyc();
            call = 1'b0;
        end
        call = 1'b0;
    endtask

    task automatic three_calls();
        for (int i = 1; i <= 3; i++) begin
            call = 1'b1;
            wait_cyc();
            call = 1'b0;
            #1;
            chk($sformatf("call%0d_wnd_sel", i), 32'(wnd_sel), 32'(i));
            chk($sformatf("call%0d_stall", i), 32'(stall), 32'd0);
        end
    endtask

    initial begin
        int  stall_cnt;
        bit  done;
        fork
            monitor_loop();
        join_none

        #3;
        chk("reset_outputs",
            32'({wnd_sel, stall, xfer_wnd, xfer_idx, mem_req, mem_wr, mem_addr, fill_reg_write, wnd_err}),
            32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        three_calls();

        exp_q.push_back(mk(1'b1, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(mk(1'b1, 8'd1, 2'd0, 2'd1));
        run_spill(stall_cnt);
        ack_direct = 1'b0;
        chk("spill_stall_cycles", 32'(stall_cnt), 32'd3);
        #1;
        chk("spill_wnd_sel", 32'(wnd_sel), 32'd0);

        ack_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ret = 1'b1;
            wait_cyc();
            ret = 1'b0;
            #1;
            chk($sformatf("ret%0d_wnd_sel", i + 1), 32'(wnd_sel), 32'(3 - i));
        end

        exp_q.push_back(mk(1'b0, 8'd1, 2'd0, 2'd1));
        exp_q.push_back(mk(1'b0, 8'd0, 2'd0, 2'd0));
        ret = 1'b1;
        #1;
        chk("fill_start_stall", 32'(stall), 32'd1);
        wait_cyc();
        ret = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!stall) begin
                done = 1'b1;
                break;
            end
            wait_cyc();
        end
        chk("fill_done", 32'(done), 32'd1);
        #1;
        chk("fill_wnd_sel", 32'(wnd_sel), 32'd0);
        chk("fill_wnd_err", 32'(wnd_err), 32'd0);

        ret = 1'b1;
        #1;
        chk("underflow_stall", 32'(stall), 32'd0);
        wait_cyc();
        ret = 1'b0;
        #1;
        chk("underflow_wnd_err", 32'(wnd_err), 32'd1);
        chk("underflow_wnd_sel", 32'(wnd_sel), 32'd0);

        ack_mode = 1'b0;
        call = 1'b1;
        wait_cyc();
        call = 1'b0;
        #1;
        chk("pre_both_wnd_sel", 32'(wnd_sel), 32'd1);
        call = 1'b1;
        ret = 1'b1;
        #1;
        chk("both_stall", 32'(stall), 32'd0);
        wait_cyc();
        call = 1'b0;
        ret = 1'b0;
        #1;
        chk("both_wnd_sel", 32'(wnd_sel), 32'd1);
        for (int i = 2; i <= 3; i++) begin
            call = 1'b1;
            wait_cyc();
            call = 1'b0;
            #1;
            chk($sformatf("refill_call_wnd_sel%0d", i), 32'(wnd_sel), 32'(i));
        end

        ack_mode = 1'b1;
        exp_q.push_back(mk(1'b1, 8'd0, 2'd0, 2'd0));
        call = 1'b1;
        #1;
        chk("both_resident_full_stall", 32'(stall), 32'd1);
        wait_cyc();
        call = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (xfer_idx == 2'd1) begin
                done = 1'b1;
                break;
            end
            wait_cyc();
        end
        chk("spill_first_ack", 32'(done), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midspill_reset_outputs",
            32'({wnd_sel, stall, xfer_wnd, xfer_idx, mem_req, mem_wr, mem_addr, fill_reg_write, wnd_err}),
            32'd0);
        ack_mode = 1'b0;
        wait_cyc();
        rst_n = 1'b1;
        #1;
        chk("post_reset_wnd_sel", 32'(wnd_sel), 32'd0);
        chk("post_reset_stall", 32'(stall), 32'd0);

        three_calls();
        exp_q.push_back(mk(1'b1, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(mk(1'b1, 8'd1, 2'd0, 2'd1));
        run_spill(stall_cnt);
        chk("post_reset_spill_stall_cycles", 32'(stall_cnt), 32'd3);

        #1;
        chk("idle_ack_fill_reg_write", 32'(fill_reg_write), 32'd0);
        chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
        wait_cyc();
        #1;
        chk("idle_ack_wnd_sel", 32'(wnd_sel), 32'd0);
        chk("idle_ack_stall", 32'(stall), 32'd0);
        ack_direct = 1'b0;

        wait_cyc();
        wait_cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
- Window-pointer controller directly upstream of the windowed register file; generates the current window select that the register file decodes into physical registers.
- Tracks call/return nesting depth.
- When all hardware windows are resident, spills the oldest window to data memory on a call.
- Fills the window back from data memory on a return, stalling the pipeline during the transfer.

Parameters:
- NUM_WND, 4, number of hardware windows; matches the 2-bit window select.
- XFER_REGS, 2, registers moved per spill/fill: the non-overlapped pair of a window, indices 0..XFER_REGS-1.
- ADDR_W, 8, width of save-area memory address.
- DEPTH_W, 4, width of the spilled-window counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Call  in  1  decoder: call instruction in current cycle.
- Ret  in  1  decoder: return instruction in current cycle.
- WndSel  out  2  current window pointer (CWP) to the register file.
- Stall  out  1  hold fetch/decode; decoder keeps Call/Ret stable while high.
- Xfer_Wnd  out  2  window being spilled/filled; datapath muxes it onto register-file WndSel while Stall=1.
- Xfer_Idx  out  2  register index within Xfer_Wnd; drives read port 1 (spill) or write port (fill).
- Mem_Req  out  1  memory request.
- Mem_Wr  out  1  1=store (spill), 0=load (fill); valid with Mem_Req.
- Mem_Addr  out  ADDR_W  save-area word address.
- Mem_Ack  in  1  memory completes request this cycle; load data valid this cycle.
- Fill_RegWrite  out  1  write memory load data into register Xfer_Wnd/Xfer_Idx this cycle.
- Wnd_Err  out  1  sticky overflow/underflow flag.

Behaviour:
- Internal state: CWP (2b), Resident (1..NUM_WND), Depth (DEPTH_W), Save_Ptr (ADDR_W), idx counter, FSM {IDLE, SPILL, FILL}.
- Reset (async, Rst=0): CWP=0, Resident=1, Depth=0, Save_Ptr=0, FSM=IDLE. All outputs 0.
- Reset asserted mid-SPILL/FILL aborts the transfer immediately, with no partial pointer update.
- Call/Ret are sampled only in IDLE. Call=Ret=1 in the same cycle is a no-op.
- IDLE, Call, Resident<NUM_WND: next edge CWP<=CWP+1 (mod 4), Resident+1. No stall.
- IDLE, Call, Resident=NUM_WND, Depth<max: enter SPILL.
  - Stall=1 combinationally from the Call cycle.
  - Xfer_Wnd=CWP+1 mod 4 (oldest window). idx=0.
- IDLE, Call, Resident=NUM_WND, Depth=max: Wnd_Err<=1, no state change.
- SPILL:
  - Outputs: Mem_Req=1, Mem_Wr=1, Mem_Addr=Save_Ptr, Xfer_Idx=idx.
  - Req, address and index are held stable until Mem_Ack.
  - On Ack: Save_Ptr+1, idx+1.
  - On Ack of idx=XFER_REGS-1: CWP+1, Depth+1, Resident unchanged, FSM=IDLE, Stall and Mem_Req drop next cycle.
  - Minimum latency XFER_REGS+1 cycles from Call to Stall low.
- IDLE, Ret, Resident>1: CWP<=CWP-1, Resident-1.
- IDLE, Ret, Resident=1, Depth>0: enter FILL.
  - Stall=1. Xfer_Wnd=CWP-1 mod 4. idx=XFER_REGS-1.
- IDLE, Ret, Resident=1, Depth=0: underflow, Wnd_Err<=1, no change.
- FILL:
  - Outputs: Mem_Req=1, Mem_Wr=0, Mem_Addr=Save_Ptr-1, Xfer_Idx=idx.
  - On Ack: Fill_RegWrite=1 in that same cycle (combinational Ack gate), Save_Ptr-1, idx-1.
  - After idx=0 acked: CWP-1, Depth-1, Resident stays 1, FSM=IDLE.
- Fill is LIFO-exact: registers return to the same indices they were spilled from.
- Mem_Ack while Mem_Req=0 is ignored. Fill_RegWrite is never asserted outside FILL.
- Save_Ptr wraps modulo 2^ADDR_W. Depth never wraps; saturation is reported via Wnd_Err.
- Wnd_Err is cleared only by reset.

Test Plan:
- Reset then three Calls in IDLE -> WndSel 1,2,3 on consecutive cycles, Stall=0, Resident=4.
- Fourth Call, Mem_Ack tied 1 -> Stall high 3 cycles.
  - Stores at Mem_Addr 0,1 with Xfer_Wnd=0, Xfer_Idx 0,1.
  - Then WndSel=0, Depth=1.
- Five Rets after previous scenario, Ack delayed 2 cycles each.
  - Three Rets are free; at Resident=1 a fill occurs: loads at Mem_Addr 1 then 0, Xfer_Idx 1 then 0, Xfer_Wnd=0.
  - Fill_RegWrite pulses coincide with Ack. Save_Ptr=0.
  - Next Ret -> Wnd_Err=1, WndSel unchanged.
- Call and Ret asserted together in IDLE -> no change in WndSel, Resident or Stall.
- Rst low during SPILL after first Ack -> all outputs 0 asynchronously, WndSel=0, Save_Ptr=0 after release.
- Mem_Ack pulsed while idle -> no Fill_RegWrite, no pointer change.
